// File: rtl/mux_scan_pkg.sv
// Shared types and default sizing for the multiplexer scan controller.
package mux_scan_pkg;

    localparam int N_CH_DEF  = 8;
    localparam int SEL_W_DEF = 3;
    localparam int DWELL_DEF = 1;
    localparam int DWELL_W   = $clog2(DWELL_DEF + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } scan_state_e;

endpackage

// File: rtl/scan_dwell_timer.sv
// Settle-time down-counter: reloads on entry to a channel, expires after DWELL cycles.
module scan_dwell_timer #(
    parameter int DWELL = 1,
    parameter int W     = $clog2(DWELL + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam logic [W-1:0] RELOAD = W'(DWELL - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (count && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Loaded with DWELL-1, so the zero count marks the last settle cycle.
    assign expire = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sequencer that walks an enable-gated N:1 mux through every channel and
// reassembles the sampled output bits into a parallel word.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int SEL_W = SEL_W_DEF,
    parameter int DWELL = DWELL_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    output logic [SEL_W-1:0] mux_s,
    output logic             mux_en,
    input  logic             mux_y,
    output logic             busy,
    output logic             done,
    output logic [N_CH-1:0]  data_out
);

    localparam int               DW_W    = $clog2(DWELL + 1);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    scan_state_e      state_q, state_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic [N_CH-1:0]  shadow_q, shadow_d;
    logic [N_CH-1:0]  data_q, data_d;
    logic             busy_q, busy_d;
    logic             mux_en_q, mux_en_d;
    logic             done_q, done_d;
    logic             cont_q, cont_d;
    logic             dwell_load;
    logic             dwell_count;
    logic             dwell_expire;
    logic             last_ch;

    assign last_ch     = (ch_q == LAST_CH);
    assign dwell_load  = (state_d == SETTLE) && (state_q != SETTLE);
    assign dwell_count = (state_q == SETTLE);

    scan_dwell_timer #(
        .DWELL (DWELL),
        .W     (DW_W)
    ) u_dwell (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (dwell_load),
        .count  (dwell_count),
        .expire (dwell_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = SETTLE;
                SETTLE:  if (dwell_expire) state_d = SAMPLE;
                SAMPLE:  state_d = last_ch ? DONE : SETTLE;
                DONE:    state_d = cont_q ? SETTLE : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // The last sample bit and data_out land on the same edge, so done sees the full word.
    always_comb begin
        busy_d   = (state_d != IDLE);
        mux_en_d = (state_d == SETTLE) || (state_d == SAMPLE);
        done_d   = (state_d == DONE);
        ch_d     = ch_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        cont_d   = cont_q;
        if (abort) begin
            ch_d     = '0;
            shadow_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ch_d   = '0;
                        cont_d = cont;
                    end
                end
                SAMPLE: begin
                    shadow_d[ch_q] = mux_y;
                    if (last_ch) begin
                        data_d = shadow_d;
                    end else begin
                        ch_d = ch_q + SEL_W'(1);
                    end
                end
                DONE: begin
                    ch_d   = '0;
                    cont_d = cont;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q     <= '0;
            shadow_q <= '0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            mux_en_q <= 1'b0;
            done_q   <= 1'b0;
            cont_q   <= 1'b0;
        end else begin
            ch_q     <= ch_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            mux_en_q <= mux_en_d;
            done_q   <= done_d;
            cont_q   <= cont_d;
        end
    end

    assign mux_s    = ch_q;
    assign mux_en   = mux_en_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench: two scan controllers (DWELL=1 and DWELL=3), each driving a
// behavioural enable-gated 8:1 mux.
module tb_mux_scan_ctrl;

    typedef struct {
        int         g;
        logic [7:0] word;
        int         done_cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      start_s;
    logic [1:0]      cont_s;
    logic [1:0]      abort_s;
    logic [1:0][7:0] d_in;
    logic [1:0][2:0] mux_s_w;
    logic [1:0]      mux_en_w;
    logic [1:0]      mux_y_w;
    logic [1:0]      busy_w;
    logic [1:0]      done_w;
    logic [1:0][7:0] data_w;

    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mux_scan_ctrl #(
            .N_CH  (8),
            .SEL_W (3),
            .DWELL ((g == 0) ? 1 : 3)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start_s[g]),
            .cont     (cont_s[g]),
            .abort    (abort_s[g]),
            .mux_s    (mux_s_w[g]),
            .mux_en   (mux_en_w[g]),
            .mux_y    (mux_y_w[g]),
            .busy     (busy_w[g]),
            .done     (done_w[g]),
            .data_out (data_w[g])
        );
        // multiplex8_1: Y follows D[S] while enabled, low otherwise.
        assign mux_y_w[g] = mux_en_w[g] ? d_in[g][mux_s_w[g]] : 1'b0;
    end

    function automatic int dwell_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic int scan_len(input int g);
        return 8 * (dwell_of(g) + 1);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic applyStimulus(input int g, input logic [7:0] d, input bit c,
                                 input bit expect_done, output int done_at);
        d_in[g]    = d;
        cont_s[g]  = c;
        start_s[g] = 1'b1;
        done_at    = cyc + 1 + scan_len(g);
        if (expect_done) exp_q.push_back('{g, d, done_at});
        @(negedge clk);
        start_s[g] = 1'b0;
    endtask

    task automatic waitCycle(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checkOutput("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    // Channel i must be presented for dwell+1 cycles, in ascending order.
    task automatic traceScan(input int g);
        for (int i = 0; i < scan_len(g); i++) begin
            checkOutput($sformatf("trace_en_dut%0d_%0d", g, i), mux_en_w[g], 1);
            checkOutput($sformatf("trace_sel_dut%0d_%0d", g, i), mux_s_w[g], i / (dwell_of(g) + 1));
            @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int g = 0; g < 2; g++) begin
            if (done_w[g] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checkOutput($sformatf("unexpected_done_dut%0d", g), done_w[g], 0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("done_dut", g, e.g);
                    checkOutput("done_word", data_w[g], e.word);
                    checkOutput("done_cycle", cyc, e.done_cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         t;
        int         k;
        int         g;
        logic [7:0] d;

        rst_n   = 1'b0;
        start_s = '0;
        cont_s  = '0;
        abort_s = '0;
        d_in    = '0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checkOutput("rst_mux_s", mux_s_w[i], 0);
            checkOutput("rst_mux_en", mux_en_w[i], 0);
            checkOutput("rst_busy", busy_w[i], 0);
            checkOutput("rst_done", done_w[i], 0);
            checkOutput("rst_data", data_w[i], 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] single scan, D=AA");
        applyStimulus(0, 8'hAA, 1'b0, 1'b1, t);
        traceScan(0);
        checkOutput("t1_done_at_latency", done_w[0], 1);
        checkOutput("t1_en_low_in_done", mux_en_w[0], 0);
        checkOutput("t1_busy_in_done", busy_w[0], 1);
        @(negedge clk);
        checkOutput("t1_busy_fall", busy_w[0], 0);
        checkOutput("t1_done_fall", done_w[0], 0);
        waitDrain(10);

        $display("[TB] continuous scan, D=3C then C3");
        applyStimulus(0, 8'h3C, 1'b1, 1'b1, t);
        exp_q.push_back('{0, 8'h3C, t + (scan_len(0) + 1)});
        exp_q.push_back('{0, 8'hC3, t + 2 * (scan_len(0) + 1)});
        exp_q.push_back('{0, 8'hC3, t + 3 * (scan_len(0) + 1)});
        waitCycle(t);
        checkOutput("t2_busy_in_done", busy_w[0], 1);
        waitCycle(t + 1);
        checkOutput("t2_restart_en", mux_en_w[0], 1);
        checkOutput("t2_restart_sel", mux_s_w[0], 0);
        waitCycle(t + scan_len(0) + 1);
        d_in[0] = 8'hC3;
        @(negedge clk);
        cont_s[0] = 1'b0;
        waitDrain(120);
        @(negedge clk);
        checkOutput("t2_idle_after_cont_drop", busy_w[0], 0);

        $display("[TB] abort mid-scan, D=FF");
        applyStimulus(0, 8'hFF, 1'b0, 1'b0, t);
        k = t - 1 - scan_len(0);
        waitCycle(k + 9);
        abort_s[0] = 1'b1;
        @(negedge clk);
        abort_s[0] = 1'b0;
        checkOutput("t3_busy", busy_w[0], 0);
        checkOutput("t3_en", mux_en_w[0], 0);
        checkOutput("t3_done", done_w[0], 0);
        checkOutput("t3_data_kept", data_w[0], 8'hC3);
        repeat (25) @(negedge clk);
        checkOutput("t3_data_still_kept", data_w[0], 8'hC3);
        checkOutput("t3_still_idle", busy_w[0], 0);

        $display("[TB] start pulses while busy, then start+abort in idle");
        applyStimulus(0, 8'h96, 1'b0, 1'b1, t);
        for (int c = 1; c < scan_len(0); c++) begin
            start_s[0] = (c == 3) || (c == 7);
            @(negedge clk);
        end
        start_s[0] = 1'b0;
        waitDrain(10);
        repeat (20) @(negedge clk);
        checkOutput("t4_no_restart", busy_w[0], 0);
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        checkOutput("t4_abort_wins_busy", busy_w[0], 0);
        checkOutput("t4_abort_wins_en", mux_en_w[0], 0);
        repeat (5) @(negedge clk);
        checkOutput("t4_abort_wins_later", busy_w[0], 0);
        checkOutput("t4_data_kept", data_w[0], 8'h96);

        $display("[TB] randomized single scans");
        for (int it = 0; it < 8; it++) begin
            g = $urandom_range(0, 1);
            d = 8'($urandom);
            applyStimulus(g, d, 1'b0, 1'b1, t);
            for (int c = 1; c < scan_len(g); c++) begin
                start_s[g] = ($urandom_range(0, 3) == 0);
                @(negedge clk);
            end
            start_s[g] = 1'b0;
            waitDrain(10);
            @(negedge clk);
            checkOutput($sformatf("rand_idle_%0d", it), busy_w[g], 0);
            checkOutput($sformatf("rand_hold_%0d", it), data_w[g], d);
        end

        $display("[TB] async reset mid-scan");
        applyStimulus(0, 8'h7E, 1'b0, 1'b0, t);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_mux_s", mux_s_w[0], 0);
        checkOutput("t5_rst_en", mux_en_w[0], 0);
        checkOutput("t5_rst_busy", busy_w[0], 0);
        checkOutput("t5_rst_done", done_w[0], 0);
        checkOutput("t5_rst_data", data_w[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(0, 8'h01, 1'b0, 1'b1, t);
        waitDrain(40);

        $display("[TB] DWELL=3 scan, D=5A");
        applyStimulus(1, 8'h5A, 1'b0, 1'b1, t);
        traceScan(1);
        checkOutput("t6_done_at_latency", done_w[1], 1);
        waitDrain(10);
        @(negedge clk);
        checkOutput("t6_busy_fall", busy_w[1], 0);
        checkOutput("t6_data", data_w[1], 8'h5A);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
